// File: rtl/register3_r.sv
// -----------------------------------------------------------------------------
// register3_r
//
// Purpose:
//   Parallel-load state register for the cntr8 counter. It holds the next-state
//   value computed by the counter logic and feeds it back as q. The register is
//   bit-sliced: one resettable D flip-flop per bit, all sharing one clock and one
//   synchronous active-low reset.
//
// Parameters:
//   WIDTH       - data width in bits, legal range 1..32 (default 3)
//   RESET_VALUE - value loaded into q when reset_n is sampled low (default 0)
//
// Ports:
//   clk     in   1      rising-edge clock
//   reset_n in   1      synchronous active-low reset, sampled only at clk rise
//   d       in   WIDTH  next-state data, sampled at clk rise
//   q       out  WIDTH  registered state, driven straight from the flops
//   load_en in   1      only when REGISTER3_R_LOAD_EN is defined: 1 loads d,
//                       0 holds q (reset still wins)
//
// Configuration:
//   REGISTER3_R_LOAD_EN - when defined, adds the load_en input. When undefined
//                         the register loads d on every edge out of reset.
//
// Handshake: none. There is no valid/ready; d is taken on every qualifying
// rising edge and q reflects it one edge later.
// -----------------------------------------------------------------------------
`timescale 1ns/100ps

module register3_r #(
    parameter int unsigned          WIDTH       = 3,
    parameter logic [WIDTH-1:0]     RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset_n,
`ifdef REGISTER3_R_LOAD_EN
    input  logic             load_en,
`endif
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Load qualifier shared by every bit slice.
    logic w_load;

`ifdef REGISTER3_R_LOAD_EN
    assign w_load = load_en;
`else
    assign w_load = 1'b1;
`endif

    logic [WIDTH-1:0] r_q;

    // One flop per bit. Reset is checked first so it overrides both d and the
    // load qualifier; X on d propagates into q on purpose.
    for (genvar gi = 0; gi < int'(WIDTH); gi++) begin : g_bit
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                r_q[gi] <= RESET_VALUE[gi];
            end else if (w_load) begin
                r_q[gi] <= d[gi];
            end
        end
    end

    // No combinational path from d to q.
    assign q = r_q;

endmodule

// File: tb/tb_register3_r.sv
`timescale 1ns/100ps

module tb_register3_r;

  localparam int W = 3;

`ifdef REGISTER3_R_LOAD_EN
  localparam bit HAS_EN = 1'b1;
`else
  localparam bit HAS_EN = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset block
  // ---------------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         load_en = 1'b1;
  logic [W-1:0] d = '0;
  logic [W-1:0] q;

  always #2 clk = ~clk;  // 4 ns period

  register3_r #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
`ifdef REGISTER3_R_LOAD_EN
    .load_en (load_en),
`endif
    .d       (d),
    .q       (q)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_q = 'x;
  logic [W-1:0] exp_v;
  int           checks = 0;
  int           errors = 0;

  // Watchdog: the run is far shorter than this.
  initial begin
    #200000;
    $display("FAIL watchdog: sim time=%0t exceeded limit", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Driver: applies one cycle of stimulus on the falling edge, updates the
  // reference model, pushes the expected q, and returns 1 ns after the rise.
  // ---------------------------------------------------------------------------
  task automatic drive_cycle(input logic [W-1:0] dv, input logic rst_v,
                             input logic en_v);
    @(negedge clk);
    d       = dv;
    reset_n = rst_v;
    load_en = en_v;
    if (!rst_v)                 model_q = '0;
    else if (en_v || !HAS_EN)   model_q = dv;
    exp_q.push_back(model_q);
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive_cycle(3'b101, 1'b0, 1'b1);
      exp_v = exp_q.pop_front();
      checks++;
      if (q !== exp_v || q !== 3'b000) begin
        errors++;
        $display("FAIL reset[%0d]: q=%b expected=%b", i, q, exp_v);
      end
    end
  endtask

  task automatic test_sequential_load();
    logic [W-1:0] seq [6];
    seq = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110};
    for (int i = 0; i < 6; i++) begin
      drive_cycle(seq[i], 1'b1, 1'b1);
      exp_v = exp_q.pop_front();
      checks++;
      if (q !== exp_v || q !== seq[i]) begin
        errors++;
        $display("FAIL seq_load[%0d]: q=%b expected=%b", i, q, seq[i]);
      end
    end
  endtask

  task automatic test_between_edges();
    drive_cycle(3'b010, 1'b1, 1'b1);
    exp_v = exp_q.pop_front();
    checks++;
    if (q !== exp_v) begin
      errors++;
      $display("FAIL between_load: q=%b expected=%b", q, exp_v);
    end
    #1;               // midway between edges
    d = 3'b111;
    #1;
    checks++;
    if (q !== 3'b010) begin
      errors++;
      $display("FAIL between_hold: q=%b expected=%b", q, 3'b010);
    end
    model_q = 3'b111;
    exp_q.push_back(model_q);
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (q !== exp_v) begin
      errors++;
      $display("FAIL between_next: q=%b expected=%b", q, exp_v);
    end
  endtask

  task automatic test_mid_reset();
    drive_cycle(3'b110, 1'b1, 1'b1);
    exp_v = exp_q.pop_front();
    checks++;
    if (q !== exp_v) begin
      errors++;
      $display("FAIL midrst_load: q=%b expected=%b", q, exp_v);
    end
    // Reset pulse entirely between edges must not disturb q.
    #0.5;
    reset_n = 1'b0;
    #0.5;
    checks++;
    if (q !== 3'b110) begin
      errors++;
      $display("FAIL midrst_pulse: q=%b expected=%b", q, 3'b110);
    end
    #1;
    reset_n = 1'b1;
    #0.5;
    checks++;
    if (q !== 3'b110) begin
      errors++;
      $display("FAIL midrst_after: q=%b expected=%b", q, 3'b110);
    end
    // Reset held across an edge clears, even with nonzero d.
    drive_cycle(3'b011, 1'b0, 1'b1);
    exp_v = exp_q.pop_front();
    checks++;
    if (q !== exp_v || q !== 3'b000) begin
      errors++;
      $display("FAIL midrst_clear: q=%b expected=%b", q, 3'b000);
    end
    drive_cycle(3'b011, 1'b1, 1'b1);
    exp_v = exp_q.pop_front();
    checks++;
    if (q !== exp_v || q !== 3'b011) begin
      errors++;
      $display("FAIL midrst_release: q=%b expected=%b", q, 3'b011);
    end
  endtask

`ifdef REGISTER3_R_LOAD_EN
  task automatic test_load_en();
    logic [W-1:0] want [5];
    logic [W-1:0] dv   [5];
    logic         rv   [5];
    logic         ev   [5];
    want = '{3'b011, 3'b011, 3'b011, 3'b100, 3'b000};
    dv   = '{3'b011, 3'b100, 3'b100, 3'b100, 3'b101};
    rv   = '{1'b1,   1'b1,   1'b1,   1'b1,   1'b0};
    ev   = '{1'b1,   1'b0,   1'b0,   1'b1,   1'b0};
    for (int i = 0; i < 5; i++) begin
      drive_cycle(dv[i], rv[i], ev[i]);
      exp_v = exp_q.pop_front();
      checks++;
      if (q !== exp_v || q !== want[i]) begin
        errors++;
        $display("FAIL load_en[%0d]: q=%b expected=%b", i, q, want[i]);
      end
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      drive_cycle(W'($urandom_range(0, (1 << W) - 1)),
                  ($urandom_range(0, 7) != 0),
                  ($urandom_range(0, 3) != 0));
      exp_v = exp_q.pop_front();
      checks++;
      if (q !== exp_v) begin
        errors++;
        $display("FAIL random[%0d]: q=%b expected=%b", i, q, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    // Alternate all-ones / all-zeros to toggle every bit each edge.
    for (int i = 0; i < 8; i++) begin
      drive_cycle((i % 2 == 0) ? 3'b111 : 3'b000, 1'b1, 1'b1);
      exp_v = exp_q.pop_front();
      checks++;
      if (q !== exp_v) begin
        errors++;
        $display("FAIL back_to_back[%0d]: q=%b expected=%b", i, q, exp_v);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_sequential_load();
    test_between_edges();
    test_mid_reset();
`ifdef REGISTER3_R_LOAD_EN
    test_load_en();
`endif
    test_back_to_back();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: leftover=%0d expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/register3_r.md
Name: register3_r

Overview:
- Parallel-load register, WIDTH bits wide (3 by default), with a synchronous active-low clear.
- Storage element for the 3-bit state of the cntr8 counter: holds the next-state value that the counter logic computes and feeds back.
- Bit-sliced: one resettable D flip-flop per bit, all sharing one clock and one reset.

Parameters:
- WIDTH, 3, data width in bits; legal range 1..32.
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into q when reset_n is sampled low.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- reset_n  input  1  synchronous active-low reset; sampled only at the rising edge of clk.
- d  input  WIDTH  next-state data, sampled at the rising edge of clk.
- q  output  WIDTH  registered state; driven directly from the flip-flops with no combinational path from d.
- load_en  input  1  present only when REGISTER3_R_LOAD_EN is defined (see Optional Feature).

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset:
  - At a rising clk edge with reset_n==0, q <= RESET_VALUE (000 by default). This overrides d and load_en.
  - reset_n has no effect between edges. Asserting or deasserting it mid-cycle changes nothing until the next rising edge.
  - Reset mid-operation clears q on the next edge regardless of prior contents.
- Power-up: q is undefined (X in simulation) until the first rising edge with reset_n==0. Benches must reset first.
- Load:
  - At a rising clk edge with reset_n==1, q <= d.
  - Latency is one cycle: d sampled at edge N appears on q immediately after edge N and holds until edge N+1.
- Hold: between edges, q is stable and changes on d are ignored.
- Width:
  - Pure storage, with no arithmetic, no wrap and no sign handling.
  - Each bit i of q is an independent flop fed by d[i]. Reset applies to all bits simultaneously.
- Simultaneous events: reset_n deasserting on the same edge that d changes still produces reset behaviour for that edge. The first load occurs at the following edge.
- No X propagation suppression: X on d loads X into q when reset_n==1.

Optional Feature:
- Macro: REGISTER3_R_LOAD_EN.
- Defined:
  - Adds the 1-bit input load_en.
  - At a rising edge with reset_n==1: load_en==1 gives q <= d; load_en==0 makes q hold its value.
  - Reset still has priority over load_en.
- Undefined:
  - No load_en port.
  - The register loads d on every edge with reset_n==1, exactly as in Behaviour.

Test Plan:
- Reset: hold reset_n=0 with d=101 across at least one rising edge -> q==000 after the edge, even though d≠0.
- Sequential load: release reset_n=1, then drive d=000, 001, 010, 100, 101, 110, one value per clock period (clk period 4 ns) -> q follows each value one edge later, exactly in that order.
- Between-edge stability: change d from 010 to 111 midway between edges -> q stays 010 until the next rising edge, then becomes 111.
- Mid-operation reset: with q=110, pulse reset_n=0 away from any edge and restore it to 1 before the next edge -> q stays 110. Then hold reset_n=0 across an edge -> q==000; release -> q loads the current d on the next edge.
- Optional feature (REGISTER3_R_LOAD_EN defined): q=011, load_en=0, d=100 over two edges -> q stays 011. Set load_en=1 -> q==100 after the next edge. reset_n=0 with load_en=0 -> q==000.
